// File: rtl/ms_timer_ctrl.sv
// -----------------------------------------------------------------------------
// ms_timer_ctrl
//
// Countdown-timer controller driven by the millisecond clock from the Divider.
// msclk is treated as an asynchronous level. It is synchronised into the clk
// domain and edge-detected into a registered one-cycle tick. A load/start/
// pause/clear state machine moves a CNT_W-bit down-counter by one on each tick
// while running. Expiry is flagged with a one-cycle pulse. With auto-reload,
// the counter restarts from the last loaded value and keeps running.
//
// Ports
//   clk           in   system clock; all logic updates on the rising edge
//   reset         in   asynchronous active-low reset
//   msclk         in   divided millisecond clock (asynchronous level)
//   load          in   pulse: count and reload value <= load_val
//   load_val      in   initial count in ms
//   start         in   pulse: begin or resume counting
//   pause         in   pulse: hold count
//   clear         in   pulse: zero count and reload value, go IDLE
//   auto_reload   in   level: on expiry, reload and keep running
//   count         out  remaining ms (registered)
//   running       out  high while state is RUN
//   expired       out  high while state is DONE
//   expire_pulse  out  one-cycle pulse on each expiry
//   state         out  IDLE=0 ARMED=1 RUN=2 PAUSE=3 DONE=4
// -----------------------------------------------------------------------------
module ms_timer_ctrl #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             msclk,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   input  logic             auto_reload,
   output logic [CNT_W-1:0] count,
   output logic             running,
   output logic             expired,
   output logic             expire_pulse,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   // ---------------------------------------------------------------------------
   // msclk synchroniser and rising-edge detector
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   tick_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], msclk};
         prev_q <= sync_q[SYNC_STAGES-1];
         // Registered so the tick lands SYNC_STAGES+1 edges after msclk rises.
         tick_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic: clear > load > start/pause > tick
   // ---------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] reload_q, reload_d;
   logic             pulse_d;

   // NOTE: every output of this block is given a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      pulse_d  = 1'b0;

      if (clear) begin
         state_d  = S_IDLE;
         count_d  = '0;
         reload_d = '0;
      end else if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         state_d  = (load_val != '0) ? S_ARMED : S_IDLE;
      end else if (start && pause) begin
         // Contradictory request: hold everything, and the tick is dropped too.
         state_d = state_q;
      end else if (start) begin
         if (state_q == S_ARMED || state_q == S_PAUSE) state_d = S_RUN;
      end else if (pause) begin
         if (state_q == S_RUN) state_d = S_PAUSE;
      end else if (tick_q && state_q == S_RUN) begin
         if (count_q > ONE) begin
            count_d = count_q - ONE;
         end else if (count_q == ONE) begin
            pulse_d = 1'b1;
            if (auto_reload) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = S_DONE;
            end
         end
         // count_q==0 cannot occur in RUN; holding keeps the counter from wrapping.
      end
   end

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   logic running_q, expired_q, pulse_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         // Decoded from the next state so the flags line up with state.
         running_q <= (state_d == S_RUN);
         expired_q <= (state_d == S_DONE);
         pulse_q   <= pulse_d;
      end
   end

   assign count        = count_q;
   assign running      = running_q;
   assign expired      = expired_q;
   assign expire_pulse = pulse_q;
   assign state        = state_q;

endmodule
